// File: rtl/arq_frame_sched_if.sv
// arq_frame_sched_if: mapper, transmitter and ARQ control signals of the frame scheduler
interface arq_frame_sched_if;
  logic [7:0]  i_frame_data;
  logic        i_frame_data_valid;
  logic        i_frame_data_fas;
  logic        o_frame_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_tx_fas;
  logic        i_tx_ready;
  logic        i_read_line_fifo;
  logic        i_send_complete;
  logic        i_arq_en;
  logic        o_busy;
  logic [3:0]  o_retry_cnt;
  logic [15:0] o_frame_cnt;
  logic        o_retry_exhausted;
  modport master (
    output i_frame_data, i_frame_data_valid, i_frame_data_fas, i_tx_ready,
           i_read_line_fifo, i_send_complete, i_arq_en,
    input  o_frame_ready, o_tx_data, o_tx_valid, o_tx_fas, o_busy,
           o_retry_cnt, o_frame_cnt, o_retry_exhausted
  );
  modport slave (
    input  i_frame_data, i_frame_data_valid, i_frame_data_fas, i_tx_ready,
           i_read_line_fifo, i_send_complete, i_arq_en,
    output o_frame_ready, o_tx_data, o_tx_valid, o_tx_fas, o_busy,
           o_retry_cnt, o_frame_cnt, o_retry_exhausted
  );
endinterface

// File: rtl/arq_frame_sched.sv
// arq_frame_sched: forwards mapper frames to the transmitter, buffers them and replays on request (optional ARQ_RETRY_LIMIT_EN bounds replays)
module arq_frame_sched #(
  parameter int FRAME_BYTES = 4164,
  parameter int ADDR_W      = 13,
  parameter int MAX_RETRY   = 3
) (
  input logic i_clk,
  input logic i_rst_n,
  arq_frame_sched_if.slave bus
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(FRAME_BYTES);
  if ((1 << ADDR_W) < FRAME_BYTES || MAX_RETRY > 15 || MAX_RETRY < 0) begin : g_cfg_err
    $error("arq_frame_sched: ADDR_W too small for FRAME_BYTES or MAX_RETRY outside 0..15");
  end
  typedef enum logic [1:0] {IDLE, PASS, WAIT_ACK, REPLAY} state_t;
  state_t r_state, w_state_nxt;
  logic [7:0] r_mem [FRAME_BYTES];
  logic [7:0] r_ram_q;
  logic r_q_vld;
  logic [ADDR_W:0] r_wr_addr, r_rd_addr, r_ld_cnt;
  logic [7:0] r_tx_data;
  logic r_tx_valid, r_tx_fas;
  logic [3:0] r_retry_cnt;
  logic [15:0] r_frame_cnt;
  logic w_free, w_xfer, w_frame_ready, w_accept, w_load_in, w_ld, w_rd_en;
  logic w_frame_inc, w_replay_start;
  logic [ADDR_W-1:0] w_waddr;
`ifdef ARQ_RETRY_LIMIT_EN
  logic r_exh, w_exhaust;
`endif
  assign w_free    = !r_tx_valid || bus.i_tx_ready;
  assign w_xfer    = r_tx_valid && bus.i_tx_ready;
  assign w_accept  = bus.i_frame_data_valid && w_frame_ready;
  assign w_load_in = w_accept && (r_state != IDLE || bus.i_frame_data_fas);
  assign w_waddr   = r_state == IDLE ? '0 : r_wr_addr[ADDR_W-1:0];
  assign w_rd_en   = r_state == REPLAY && r_rd_addr != FULL && (!r_q_vld || w_ld);
  // next state, mapper accept and replay load decisions
  always_comb begin
    w_state_nxt    = r_state;
    w_frame_ready  = 1'b0;
    w_frame_inc    = 1'b0;
    w_replay_start = 1'b0;
    w_ld           = 1'b0;
`ifdef ARQ_RETRY_LIMIT_EN
    w_exhaust      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_frame_ready = 1'b1;
        w_state_nxt   = bus.i_frame_data_valid && bus.i_frame_data_fas ? PASS : IDLE;
      end
      PASS: begin
        w_frame_ready = w_free && r_wr_addr != FULL;
        if (w_xfer && r_wr_addr == FULL) begin
          w_state_nxt = bus.i_arq_en ? WAIT_ACK : IDLE;
          w_frame_inc = !bus.i_arq_en;
        end
      end
      WAIT_ACK: begin
        if (bus.i_send_complete) begin
          w_state_nxt = IDLE;
          w_frame_inc = 1'b1;
        end else if (!bus.i_arq_en) w_state_nxt = IDLE;
`ifdef ARQ_RETRY_LIMIT_EN
        else if (bus.i_read_line_fifo && r_retry_cnt == 4'(MAX_RETRY)) begin
          w_state_nxt = IDLE;
          w_exhaust   = 1'b1;
        end
`endif
        else if (bus.i_read_line_fifo) begin
          w_state_nxt    = REPLAY;
          w_replay_start = 1'b1;
        end
      end
      REPLAY: begin
        w_ld        = r_q_vld && w_free;
        w_state_nxt = w_xfer && r_ld_cnt == FULL ? WAIT_ACK : REPLAY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge i_clk) r_state <= !i_rst_n ? IDLE : w_state_nxt;
  // frame buffer: capture fresh bytes, prefetch replay bytes one cycle ahead
  always_ff @(posedge i_clk) begin
    if (w_load_in) r_mem[w_waddr] <= bus.i_frame_data;
    if (w_rd_en) r_ram_q <= r_mem[r_rd_addr[ADDR_W-1:0]];
  end
  // output stage, addresses and counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_fas    <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_ld_cnt    <= '0;
      r_q_vld     <= 1'b0;
      r_retry_cnt <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load_in) begin
        r_tx_data  <= bus.i_frame_data;
        r_tx_valid <= 1'b1;
        r_tx_fas   <= r_state == IDLE;
      end else if (w_ld) begin
        r_tx_data  <= r_ram_q;
        r_tx_valid <= 1'b1;
        r_tx_fas   <= r_ld_cnt == '0;
      end else if (w_xfer) begin
        r_tx_valid <= 1'b0;
        r_tx_fas   <= 1'b0;
      end
      if (w_load_in) r_wr_addr <= r_state == IDLE ? (ADDR_W+1)'(1) : r_wr_addr + 1'b1;
      if (w_replay_start) begin
        r_rd_addr <= '0;
        r_ld_cnt  <= '0;
        r_q_vld   <= 1'b0;
      end else begin
        if (w_rd_en) r_rd_addr <= r_rd_addr + 1'b1;
        if (w_ld) r_ld_cnt <= r_ld_cnt + 1'b1;
        r_q_vld <= w_rd_en || (r_q_vld && !w_ld);
      end
      if (w_load_in && r_state == IDLE) r_retry_cnt <= '0;
      else if (w_replay_start && r_retry_cnt != 4'hf) r_retry_cnt <= r_retry_cnt + 4'd1;
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`ifdef ARQ_RETRY_LIMIT_EN
  // one-cycle pulse when the replay budget is spent
  always_ff @(posedge i_clk) r_exh <= i_rst_n && w_exhaust;
  assign bus.o_retry_exhausted = r_exh;
`else
  assign bus.o_retry_exhausted = 1'b0;
`endif
  assign bus.o_frame_ready = w_frame_ready;
  assign bus.o_tx_data     = r_tx_data;
  assign bus.o_tx_valid    = r_tx_valid;
  assign bus.o_tx_fas      = r_tx_fas;
  assign bus.o_busy        = r_state != IDLE;
  assign bus.o_retry_cnt   = r_retry_cnt;
  assign bus.o_frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_arq_frame_sched.sv
// tb_arq_frame_sched: random-stimulus bench comparing the transmit stream against a frame-level queue model
module tb_arq_frame_sched;
  localparam int N = 4164;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  arq_frame_sched_if bus();
  arq_frame_sched #(.FRAME_BYTES(N), .ADDR_W(13), .MAX_RETRY(3)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] fr [N];
  logic [8:0] exp_q [$];
  int m_idx, m_midfas, rdy_pct, xfers, exp_fc, exp_rc;
  bit m_on, p_stall;
  logic [8:0] p_out;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic drive_map();
    if (m_on) begin
      bus.i_frame_data_valid = m_idx < N && $urandom_range(9) != 0;
      bus.i_frame_data       = m_idx < N ? fr[m_idx] : 8'h00;
      bus.i_frame_data_fas   = m_idx == 0 || m_idx == m_midfas;
    end
  endtask
  task automatic step();
    bit acc;
    logic [7:0] acc_d;
    @(negedge clk);
    acc   = m_on && bus.i_frame_data_valid && bus.o_frame_ready;
    acc_d = bus.i_frame_data;
    if (p_stall) check("hold", 32'({bus.o_tx_valid, bus.o_tx_fas, bus.o_tx_data}), 32'({1'b1, p_out}));
    if (bus.o_tx_valid && bus.i_tx_ready) begin
      xfers++;
      if (exp_q.size() == 0) check("unexpected_byte", 32'(exp_q.size()), 1);
      else check("tx_byte", 32'({bus.o_tx_fas, bus.o_tx_data}), 32'(exp_q.pop_front()));
    end
    p_stall = bus.o_tx_valid && !bus.i_tx_ready;
    p_out   = {bus.o_tx_fas, bus.o_tx_data};
    @(posedge clk);
    #1;
    if (acc) begin
      check("latency", 32'({bus.o_tx_valid, bus.o_tx_data}), 32'({1'b1, acc_d}));
      m_idx++;
    end
    drive_map();
    bus.i_tx_ready = $urandom_range(99) < rdy_pct;
  endtask
  task automatic new_frame(input bit seq, input int mid);
    for (int i = 0; i < N; i++) begin
      fr[i] = seq ? 8'(i) : 8'($urandom);
      exp_q.push_back({1'(i == 0), fr[i]});
    end
    m_idx = 0;
    m_midfas = mid;
    m_on = 1'b1;
    exp_rc = 0;
    drive_map();
  endtask
  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || (m_on && m_idx < N)) && k < 40000) begin
      step();
      k++;
    end
    check(tag, 32'(exp_q.size()), 0);
    m_on = 1'b0;
    bus.i_frame_data_valid = 1'b0;
  endtask
  task automatic replay(input int hold);
    for (int i = 0; i < N; i++) exp_q.push_back({1'(i == 0), fr[i]});
    bus.i_read_line_fifo = 1'b1;
    for (int k = 0; k < hold; k++) step();
    bus.i_read_line_fifo = 1'b0;
    exp_rc++;
    drain("replay_drain");
    check("replay_retry_cnt", 32'(bus.o_retry_cnt), exp_rc);
    check("replay_wait_busy", 32'(bus.o_busy), 1);
  endtask
  task automatic ack(input int wait_n);
    bus.i_frame_data_valid = 1'b1;
    bus.i_frame_data_fas   = 1'b1;
    for (int k = 0; k < wait_n; k++) begin
      step();
      check("wait_ready", 32'(bus.o_frame_ready), 0);
      check("wait_valid", 32'(bus.o_tx_valid), 0);
    end
    bus.i_frame_data_valid = 1'b0;
    bus.i_send_complete = 1'b1;
    step();
    bus.i_send_complete = 1'b0;
    exp_fc++;
    check("ack_frame_cnt", 32'(bus.o_frame_cnt), exp_fc);
    check("ack_idle", 32'(bus.o_busy), 0);
    check("ack_retry_cnt", 32'(bus.o_retry_cnt), exp_rc);
  endtask
  initial begin
    bus.i_frame_data = '0;
    bus.i_frame_data_valid = 1'b0;
    bus.i_frame_data_fas = 1'b0;
    bus.i_tx_ready = 1'b1;
    bus.i_read_line_fifo = 1'b0;
    bus.i_send_complete = 1'b0;
    bus.i_arq_en = 1'b0;
    rdy_pct = 100;
    m_on = 1'b0;
    m_midfas = -1;
    p_stall = 1'b0;
    xfers = 0;
    exp_fc = 0;
    exp_rc = 0;
    repeat (3) step();
    check("rst_valid", 32'(bus.o_tx_valid), 0);
    check("rst_data", 32'({bus.o_tx_fas, bus.o_tx_data}), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_cnts", 32'({bus.o_retry_cnt, bus.o_frame_cnt}), 0);
    check("rst_exhausted", 32'(bus.o_retry_exhausted), 0);
    rst_n = 1'b1;
    bus.i_frame_data_valid = 1'b1;
    bus.i_frame_data = 8'ha5;
    repeat (5) step();
    bus.i_frame_data_valid = 1'b0;
    check("junk_dropped_idle", 32'(bus.o_busy), 0);
    check("idle_ready", 32'(bus.o_frame_ready), 1);
    new_frame(1'b1, -1);
    drain("plain_drain");
    exp_fc++;
    check("plain_frame_cnt", 32'(bus.o_frame_cnt), exp_fc);
    check("plain_idle", 32'(bus.o_busy), 0);
    bus.i_arq_en = 1'b1;
    new_frame(1'b0, 1000);
    drain("arq_drain");
    check("arq_wait_busy", 32'(bus.o_busy), 1);
    ack(20);
    new_frame(1'b0, -1);
    drain("rtx_drain");
    replay(1);
    ack(3);
    rdy_pct = 50;
    new_frame(1'b0, 2500);
    drain("stall_drain");
    replay(30);
    ack(5);
    rdy_pct = 100;
    new_frame(1'b0, -1);
    drain("abandon_drain");
    bus.i_arq_en = 1'b0;
    step();
    check("abandon_idle", 32'(bus.o_busy), 0);
    check("abandon_frame_cnt", 32'(bus.o_frame_cnt), exp_fc);
    bus.i_arq_en = 1'b1;
    new_frame(1'b0, -1);
    drain("rstrep_drain");
    for (int i = 0; i < N; i++) exp_q.push_back({1'(i == 0), fr[i]});
    bus.i_read_line_fifo = 1'b1;
    step();
    bus.i_read_line_fifo = 1'b0;
    xfers = 0;
    for (int k = 0; k < 10000 && xfers < 2000; k++) step();
    check("rstrep_reached", 32'(xfers), 2000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    p_stall = 1'b0;
    exp_fc = 0;
    exp_rc = 0;
    check("rstrep_valid", 32'({bus.o_tx_valid, bus.o_tx_fas, bus.o_tx_data}), 0);
    check("rstrep_busy", 32'(bus.o_busy), 0);
    check("rstrep_cnts", 32'({bus.o_retry_cnt, bus.o_frame_cnt}), 0);
    bus.i_arq_en = 1'b0;
    new_frame(1'b0, -1);
    drain("post_rst_drain");
    exp_fc++;
    check("post_rst_frame_cnt", 32'(bus.o_frame_cnt), exp_fc);
`ifdef ARQ_RETRY_LIMIT_EN
    bus.i_arq_en = 1'b1;
    new_frame(1'b0, -1);
    drain("limit_drain");
    repeat (3) replay(1);
    bus.i_read_line_fifo = 1'b1;
    step();
    bus.i_read_line_fifo = 1'b0;
    check("limit_pulse", 32'(bus.o_retry_exhausted), 1);
    check("limit_idle", 32'(bus.o_busy), 0);
    step();
    check("limit_pulse_end", 32'(bus.o_retry_exhausted), 0);
    check("limit_frame_cnt", 32'(bus.o_frame_cnt), exp_fc);
    repeat (20) step();
    check("limit_no_replay", 32'(exp_q.size() + xfers * 0), 0);
`else
    check("no_limit_exhausted", 32'(bus.o_retry_exhausted), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/arq_frame_sched.md
Name: arq_frame_sched

Overview:
- Sits between the OTN mapper and the serial transmit/ARQ block.
- Forwards each new 4164-byte frame to the transmitter and captures a copy in an internal frame buffer.
- Holds off the mapper while an ACK is outstanding, and replays the buffered frame on a retransmit request.
- Shares the single transmitter input between two requesters: fresh mapper traffic and buffer replay.

Parameters:
- FRAME_BYTES, 4164, bytes per OTN frame, including FAS bytes.
- ADDR_W, 13, frame buffer address width; 2^ADDR_W must be >= FRAME_BYTES.
- MAX_RETRY, 3, replay limit; used only with ARQ_RETRY_LIMIT_EN.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_frame_data  in  8  mapper byte.
- i_frame_data_valid  in  1  mapper byte valid.
- i_frame_data_fas  in  1  marks the first byte of a frame; qualified by valid.
- o_frame_ready  out  1  accept to mapper.
- o_tx_data  out  8  byte to transmitter.
- o_tx_valid  out  1  byte valid to transmitter.
- o_tx_fas  out  1  high with the first byte of every frame, fresh or replayed.
- i_tx_ready  in  1  transmitter input FIFO ready.
- i_read_line_fifo  in  1  retransmit request from transmitter (level).
- i_send_complete  in  1  good-ACK pulse from transmitter.
- i_arq_en  in  1  ARQ enable switch.
- o_busy  out  1  state != IDLE.
- o_retry_cnt  out  4  replays of the current frame, saturating at 15.
- o_frame_cnt  out  16  frames completed, wrapping.
- o_retry_exhausted  out  1  one-cycle pulse; optional feature only, otherwise tied 0.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - State goes to IDLE; all outputs and counters are 0; wr_addr and rd_addr are 0.
  - Reset takes effect in any state. A partial frame is discarded and buffer contents are don't-care.
- Output stage:
  - One register holds o_tx_data, o_tx_valid and o_tx_fas.
  - A byte is transferred when o_tx_valid && i_tx_ready.
  - While o_tx_valid is high and i_tx_ready is low, data and fas are held stable.
- Frame buffer:
  - Inferred simple dual-port RAM, FRAME_BYTES deep, 8 bits wide, synchronous read with 1-cycle latency.
- States:
  - IDLE:
    - o_frame_ready = 1. Bytes without fas are dropped and not forwarded.
    - A byte with valid && fas is loaded into the output stage and written to RAM[0]. wr_addr becomes 1, o_retry_cnt is cleared, next state is PASS.
  - PASS:
    - o_frame_ready = !o_tx_valid || i_tx_ready.
    - Each accepted mapper byte is loaded into the output stage and written to RAM[wr_addr]; wr_addr increments.
    - A fas seen mid-frame is forwarded as data and not restarted.
    - When byte FRAME_BYTES has transferred out of the output stage: go to WAIT_ACK if i_arq_en, else go to IDLE and increment o_frame_cnt.
  - WAIT_ACK:
    - o_frame_ready = 0; o_tx_valid = 0.
    - Events are evaluated in this priority order:
      - i_send_complete: go to IDLE, o_frame_cnt +1.
      - !i_arq_en: go to IDLE, frame is abandoned and not counted.
      - i_read_line_fifo: go to REPLAY, rd_addr = 0, o_retry_cnt +1 (saturating).
  - REPLAY:
    - o_frame_ready = 0.
    - RAM is read with prefetch so the output stage sustains one byte per cycle when i_tx_ready is held high.
    - The first replayed byte has o_tx_fas = 1.
    - After FRAME_BYTES bytes have transferred: go to WAIT_ACK.
    - i_read_line_fifo held high during REPLAY is ignored. Only a level seen in WAIT_ACK starts a new replay.
- Latency: a mapper byte appears on o_tx_data in the cycle after acceptance. This holds in PASS and for the frame-starting fas byte accepted in IDLE.
- Address arithmetic: FRAME_BYTES-1 is the last index; wr_addr and rd_addr never wrap within a frame.
- i_arq_en sampling: sampled only at the PASS exit and in WAIT_ACK. Changes mid-PASS have no effect.

Optional Feature:
- ARQ_RETRY_LIMIT_EN
  - Defined: in WAIT_ACK, if i_read_line_fifo is asserted while o_retry_cnt == MAX_RETRY, the block pulses o_retry_exhausted for 1 cycle and goes to IDLE without replaying or incrementing o_frame_cnt.
  - Not defined: retries are unbounded and o_retry_exhausted is constant 0.

Test Plan:
- i_arq_en = 0; mapper sends a 4164-byte frame (fas on byte 0, data = index mod 256); i_tx_ready = 1 -> 4164 bytes out in order, o_tx_fas on byte 0 only, o_frame_cnt = 1, state IDLE.
- i_arq_en = 1; one frame, then i_send_complete pulse 20 cycles later -> o_frame_ready = 0 during the wait, o_frame_cnt = 1, o_retry_cnt = 0.
- i_arq_en = 1; frame, then i_read_line_fifo, then i_send_complete after the replay -> replay is byte-identical to the original with fas on byte 0, o_retry_cnt = 1, o_frame_cnt = 1.
- Random i_tx_ready (50% duty) during PASS and REPLAY -> no lost or duplicated bytes; output held stable while stalled; total of 4164 transfers per pass.
- i_rst_n low for 1 cycle at byte 2000 of REPLAY -> next cycle all outputs 0 and IDLE; next fas frame forwarded normally.
- ARQ_RETRY_LIMIT_EN, MAX_RETRY = 3; 4 retransmit requests -> 3 replays, then o_retry_exhausted pulses once, IDLE, o_frame_cnt unchanged.
